// File: rtl/snn_pkg.sv
// Shared types and helpers for the SNN input/neuron datapath.
// Holds the encoder state type and the spike-to-data mapping.
package snn_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ENC_IDLE = 2'd0,
        ENC_RUN  = 2'd1,
        ENC_DONE = 2'd2
    } enc_state_t;

    function automatic logic [DATA_W-1:0] spike_out(
        input logic              spike,
        input logic [DATA_W-1:0] val
    );
        return spike ? val : '0;
    endfunction

endpackage

// File: rtl/rate_enc_channel.sv
// One sigma-delta rate-coding channel: pixel register, accumulator, add.
// The spike is the carry out of acc + pix for the current timestep.
module rate_enc_channel
    import snn_pkg::*;
#(
    parameter logic [DATA_W-1:0] ACC_INIT = 8'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] pix,
    output logic              spike
);

    logic [DATA_W-1:0] pix_q;
    logic [DATA_W-1:0] acc;
    logic [DATA_W:0]   sum;

    assign sum   = {1'b0, acc} + {1'b0, pix_q};
    assign spike = sum[DATA_W];

    // Capture the pixel at window start; integrate once per timestep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_q <= '0;
            acc   <= '0;
        end else if (load) begin
            pix_q <= pix;
            acc   <= ACC_INIT;
        end else if (step) begin
            acc <= sum[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/spike_rate_encoder.sv
// Three-channel rate-coded spike encoder feeding the middle neuron layer.
// Emits NUM_STEPS timesteps per window, one per clock, then a done pulse.
module spike_rate_encoder
    import snn_pkg::*;
#(
    parameter int                NUM_STEPS = 256,
    parameter logic [DATA_W-1:0] SPIKE_VAL = 8'd1,
    parameter logic [DATA_W-1:0] ACC_INIT  = 8'd0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic [DATA_W-1:0] i_pix0,
    input  logic [DATA_W-1:0] i_pix1,
    input  logic [DATA_W-1:0] i_pix2,
    output logic [DATA_W-1:0] o_data0,
    output logic [DATA_W-1:0] o_data1,
    output logic [DATA_W-1:0] o_data2,
    output logic              o_valid,
    output logic              o_busy,
    output logic              o_done
);

    localparam int CW = $clog2(NUM_STEPS + 1);
    localparam logic [CW-1:0] LAST = CW'(NUM_STEPS - 1);

    enc_state_t        state;
    enc_state_t        next;
    logic              load;
    logic              run;
    logic              emit;
    logic [CW-1:0]     step_cnt;
    logic [2:0]        spike;
    logic [DATA_W-1:0] pix [3];

    assign pix[0] = i_pix0;
    assign pix[1] = i_pix1;
    assign pix[2] = i_pix2;

    for (genvar c = 0; c < 3; c++) begin : g_ch
        rate_enc_channel #(
            .ACC_INIT (ACC_INIT)
        ) u_ch (
            .clk   (i_clk),
            .rst   (i_rst),
            .load  (load),
            .step  (run),
            .pix   (pix[c]),
            .spike (spike[c])
        );
    end

    // A stop in the same cycle as the final step aborts without done.
    assign emit = run && !i_stop;

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ENC_IDLE;
        end else begin
            state <= next;
        end
    end

    // Next-state and control decode.
    always_comb begin
        next = state;
        load = 1'b0;
        run  = 1'b0;
        unique case (state)
            ENC_IDLE: begin
                if (i_start) begin
                    next = ENC_RUN;
                    load = 1'b1;
                end
            end
            ENC_RUN: begin
                run = 1'b1;
                if (i_stop) begin
                    next = ENC_IDLE;
                end else if (step_cnt == LAST) begin
                    next = ENC_DONE;
                end
            end
            ENC_DONE: begin
                next = ENC_IDLE;
            end
            default: begin
                next = ENC_IDLE;
            end
        endcase
    end

    // Timestep counter, cleared when a window is accepted.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            step_cnt <= '0;
        end else if (load) begin
            step_cnt <= '0;
        end else if (run) begin
            step_cnt <= step_cnt + 1'b1;
        end
    end

    // Registered outputs: spike data, valid, busy and done pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_data0 <= '0;
            o_data1 <= '0;
            o_data2 <= '0;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            o_busy <= (next != ENC_IDLE);
            o_done <= (state == ENC_DONE);
            if (emit) begin
                o_data0 <= spike_out(spike[0], SPIKE_VAL);
                o_data1 <= spike_out(spike[1], SPIKE_VAL);
                o_data2 <= spike_out(spike[2], SPIKE_VAL);
                o_valid <= 1'b1;
            end else begin
                o_data0 <= '0;
                o_data1 <= '0;
                o_data2 <= '0;
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Self-checking bench for spike_rate_encoder.
// Three instances: 256-step window, 1-step window, 37-step rounding window.
module tb_spike_rate_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start [3];
    logic       stop  [3];
    logic [7:0] px0   [3];
    logic [7:0] px1   [3];
    logic [7:0] px2   [3];
    logic [7:0] d0    [3];
    logic [7:0] d1    [3];
    logic [7:0] d2    [3];
    logic       valid [3];
    logic       busy  [3];
    logic       done  [3];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spike_rate_encoder #(
        .NUM_STEPS (256), .SPIKE_VAL (8'd1), .ACC_INIT (8'd0)
    ) u0 (
        .i_clk (clk), .i_rst (rst), .i_start (start[0]), .i_stop (stop[0]),
        .i_pix0 (px0[0]), .i_pix1 (px1[0]), .i_pix2 (px2[0]),
        .o_data0 (d0[0]), .o_data1 (d1[0]), .o_data2 (d2[0]),
        .o_valid (valid[0]), .o_busy (busy[0]), .o_done (done[0])
    );

    spike_rate_encoder #(
        .NUM_STEPS (1), .SPIKE_VAL (8'd1), .ACC_INIT (8'd0)
    ) u1 (
        .i_clk (clk), .i_rst (rst), .i_start (start[1]), .i_stop (stop[1]),
        .i_pix0 (px0[1]), .i_pix1 (px1[1]), .i_pix2 (px2[1]),
        .o_data0 (d0[1]), .o_data1 (d1[1]), .o_data2 (d2[1]),
        .o_valid (valid[1]), .o_busy (busy[1]), .o_done (done[1])
    );

    spike_rate_encoder #(
        .NUM_STEPS (37), .SPIKE_VAL (8'd1), .ACC_INIT (8'h80)
    ) u2 (
        .i_clk (clk), .i_rst (rst), .i_start (start[2]), .i_stop (stop[2]),
        .i_pix0 (px0[2]), .i_pix1 (px1[2]), .i_pix2 (px2[2]),
        .o_data0 (d0[2]), .o_data1 (d1[2]), .o_data2 (d2[2]),
        .o_valid (valid[2]), .o_busy (busy[2]), .o_done (done[2])
    );

    function automatic int ns_of(input int i);
        return (i == 0) ? 256 : (i == 1) ? 1 : 37;
    endfunction

    function automatic int init_of(input int i);
        return (i == 2) ? 128 : 0;
    endfunction

    // Step k spikes when the running total init + k*pix crosses a multiple of 256.
    function automatic logic [7:0] exp_data(input int p, input int init, input int k);
        return (((init + (k + 1) * p) / 256) != ((init + k * p) / 256)) ? 8'd1 : 8'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input int i, input string tag);
        chk({tag, "_valid"}, 32'(valid[i]), 0);
        chk({tag, "_busy"},  32'(busy[i]),  0);
        chk({tag, "_done"},  32'(done[i]),  0);
        chk({tag, "_d0"},    32'(d0[i]),    0);
        chk({tag, "_d1"},    32'(d1[i]),    0);
        chk({tag, "_d2"},    32'(d2[i]),    0);
    endtask

    // One window on instance i; stop_at >= 0 raises i_stop while that step is computed.
    task automatic window(input int i, input logic [7:0] p0, input logic [7:0] p1,
                          input logic [7:0] p2, input int stop_at, input bit poke);
        int n;
        int init;
        int c0;
        int c1;
        int c2;
        n    = ns_of(i);
        init = init_of(i);
        c0   = 0;
        c1   = 0;
        c2   = 0;
        px0[i]   = p0;
        px1[i]   = p1;
        px2[i]   = p2;
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
        chk("busy_rise", 32'(busy[i]), 1);
        chk("valid_lat", 32'(valid[i]), 0);
        px0[i] = 8'($urandom);
        px1[i] = 8'($urandom);
        px2[i] = 8'($urandom);
        for (int k = 0; k < n; k++) begin
            if (poke) start[i] = (k == 3);
            if (stop_at == k) stop[i] = 1'b1;
            @(negedge clk);
            stop[i] = 1'b0;
            if (stop_at == k) begin
                check_quiet(i, "abort");
                @(negedge clk);
                check_quiet(i, "abort_after");
                return;
            end
            chk("run_valid", 32'(valid[i]), 1);
            chk("run_busy",  32'(busy[i]),  1);
            chk("run_done",  32'(done[i]),  0);
            chk("run_d0", 32'(d0[i]), 32'(exp_data(int'(p0), init, k)));
            chk("run_d1", 32'(d1[i]), 32'(exp_data(int'(p1), init, k)));
            chk("run_d2", 32'(d2[i]), 32'(exp_data(int'(p2), init, k)));
            if (p1 == 8'd128 && init == 0 && k < 4)
                chk("phase_d1", 32'(d1[i]), 32'(k % 2));
            c0 += int'(d0[i]);
            c1 += int'(d1[i]);
            c2 += int'(d2[i]);
        end
        start[i] = poke;
        @(negedge clk);
        start[i] = 1'b0;
        chk("done_pulse", 32'(done[i]),  1);
        chk("done_valid", 32'(valid[i]), 0);
        chk("done_busy",  32'(busy[i]),  0);
        chk("done_d0",    32'(d0[i]),    0);
        @(negedge clk);
        check_quiet(i, "post_done");
        chk("count0", 32'(c0), 32'((init + n * int'(p0)) / 256 - init / 256));
        chk("count1", 32'(c1), 32'((init + n * int'(p1)) / 256 - init / 256));
        chk("count2", 32'(c2), 32'((init + n * int'(p2)) / 256 - init / 256));
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            stop[i]  = 1'b0;
            px0[i]   = '0;
            px1[i]   = '0;
            px2[i]   = '0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) check_quiet(i, "reset");
        rst = 1'b0;
        @(negedge clk);

        window(0, 8'd0, 8'd255, 8'd128, -1, 1'b0);
        window(0, 8'd5, 8'd128, 8'd77, -1, 1'b1);
        window(0, 8'd200, 8'd1, 8'd3, -1, 1'b0);
        window(0, 8'($urandom), 8'($urandom), 8'($urandom), 10, 1'b0);
        window(0, 8'($urandom), 8'($urandom), 8'($urandom), 255, 1'b0);
        repeat (3) window(0, 8'($urandom), 8'($urandom), 8'($urandom), -1, 1'b0);

        window(1, 8'd255, 8'd255, 8'd255, -1, 1'b0);
        window(1, 8'd255, 8'd255, 8'd255, 0, 1'b0);

        repeat (2) window(2, 8'($urandom), 8'($urandom), 8'($urandom), -1, 1'b0);
        window(2, 8'd200, 8'd100, 8'd255, 5, 1'b0);

        px0[0]   = 8'd255;
        px1[0]   = 8'd255;
        px2[0]   = 8'd255;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (20) @(negedge clk);
        chk("pre_rst_valid", 32'(valid[0]), 1);
        #2 rst = 1'b1;
        #1;
        check_quiet(0, "async_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_quiet(0, "post_rst");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
